// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-requester burst arbiter feeding the write side of an async FIFO
// Optional macro FIFO_ALMOST_FULL_EN enables the registered almost-full comparator.
module fifo_wr_arbiter #(
  parameter int ASIZE     = 4,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4,
  parameter int AF_LEVEL  = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             req0,
  input  logic             req1,
  input  logic [DSIZE-1:0] wdata0,
  input  logic [DSIZE-1:0] wdata1,
  input  logic [ASIZE:0]   w_rptr,
  output logic             ack0,
  output logic             ack1,
  output logic             mem_we,
  output logic [ASIZE-1:0] mem_waddr,
  output logic [DSIZE-1:0] mem_wdata,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             wafull
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state;
  logic             last;
  logic [3:0]       cnt;
  logic [ASIZE:0]   wbin;
  logic [ASIZE:0]   bin_next;
  logic [ASIZE:0]   gray_next;
  logic             own_req;
  logic             oth_req;
  logic             burst_done;

  if (BURST_LEN < 1 || BURST_LEN > 15 || AF_LEVEL < 0 || AF_LEVEL > (1 << ASIZE)) begin : g_bad_param
    $error("fifo_wr_arbiter: BURST_LEN or AF_LEVEL out of range");
  end

  always_comb begin
    ack0 = (state == OWN0) && req0 && !wfull;
    ack1 = (state == OWN1) && req1 && !wfull;
  end

  assign mem_we     = ack0 | ack1;
  assign mem_waddr  = wbin[ASIZE-1:0];
  assign mem_wdata  = (state == OWN1) ? wdata1 : wdata0;
  assign bin_next   = wbin + {{ASIZE{1'b0}}, mem_we};
  assign gray_next  = bin_next ^ (bin_next >> 1);
  assign own_req    = (state == OWN1) ? req1 : req0;
  assign oth_req    = (state == OWN1) ? req0 : req1;
  assign burst_done = mem_we && (cnt == 4'(BURST_LEN - 1));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 4'd0;
      wbin  <= '0;
      wptr  <= '0;
      wfull <= 1'b0;
    end else begin
      wbin  <= bin_next;
      wptr  <= gray_next;
      // Full when the next write pointer laps the read pointer by exactly one depth.
      wfull <= (gray_next == {~w_rptr[ASIZE:ASIZE-1], w_rptr[ASIZE-2:0]});
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) state <= OWN0;
          else if (req1)               state <= OWN1;
        end
        default: begin
          if (!wfull) begin
            if (burst_done || !own_req) begin
              last  <= (state == OWN1);
              cnt   <= 4'd0;
              state <= oth_req ? ((state == OWN1) ? OWN0 : OWN1) : IDLE;
            end else if (mem_we) begin
              cnt <= cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ASIZE:0] fill;
  assign fill = bin_next - gray2bin(w_rptr);

  always_ff @(posedge wclk) begin
    if (wrst) wafull <= 1'b0;
    else      wafull <= (fill >= (ASIZE+1)'((1 << ASIZE) - AF_LEVEL));
  end
`else
  assign wafull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       req0, req1;
  logic [7:0] wdata0, wdata1;
  logic [4:0] w_rptr;
  logic       ack0, ack1, mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [4:0] wptr;
  logic       wfull, wafull;

  int n_chk  = 0;
  int n_fail = 0;
  int writes;
  int owner;

  fifo_wr_arbiter #(.ASIZE(4), .DSIZE(8), .BURST_LEN(4), .AF_LEVEL(2)) dut (
    .wclk(wclk), .wrst(wrst), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .w_rptr(w_rptr),
    .ack0(ack0), .ack1(ack1), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .wptr(wptr), .wfull(wfull), .wafull(wafull)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic af_exp(input int n);
`ifdef FIFO_ALMOST_FULL_EN
    return (n >= 14);
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    wrst = 1'b1; req0 = 1'b0; req1 = 1'b0; w_rptr = 5'd0;
    tick();
    wrst = 1'b0;
  endtask

  initial begin
    wdata0 = 8'h00; wdata1 = 8'h00;
    // Reset state
    do_reset();
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wafull", wafull, 0);

    // Three-word single requester burst
    req0 = 1'b1; wdata0 = 8'hA0;
    #1 chk("s1_idle_ack0", ack0, 0);
    tick(); #1;
    chk("s1_w0_ack0", ack0, 1); chk("s1_w0_addr", mem_waddr, 0);
    chk("s1_w0_data", mem_wdata, 8'hA0); chk("s1_w0_wptr", wptr, 0);
    tick(); wdata0 = 8'hA1; #1;
    chk("s1_w1_ack0", ack0, 1); chk("s1_w1_addr", mem_waddr, 1); chk("s1_w1_wptr", wptr, 1);
    tick(); wdata0 = 8'hA2; #1;
    chk("s1_w2_ack0", ack0, 1); chk("s1_w2_addr", mem_waddr, 2); chk("s1_w2_wptr", wptr, 3);
    chk("s1_w2_data", mem_wdata, 8'hA2);
    tick(); req0 = 1'b0; #1;
    chk("s1_end_ack0", ack0, 0); chk("s1_end_we", mem_we, 0); chk("s1_end_wptr", wptr, 2);
    tick(); #1;
    chk("s1_idle_wptr", wptr, 2);

    // Both requesters continuously high: alternating bursts of four
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    #1 chk("s2_idle_we", mem_we, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      wdata0 = 8'(k); wdata1 = 8'h80 | 8'(k);
      #1;
      owner = (k / 4) % 2;
      chk($sformatf("s2_ack0_%0d", k), ack0, (owner == 0));
      chk($sformatf("s2_ack1_%0d", k), ack1, (owner == 1));
      chk($sformatf("s2_addr_%0d", k), mem_waddr, k);
      chk($sformatf("s2_data_%0d", k), mem_wdata, (owner == 1) ? (8'h80 | 8'(k)) : 8'(k));
    end

    // Fill to full with the read pointer parked at zero
    do_reset();
    req0 = 1'b1; req1 = 1'b0;
    writes = 0;
    for (int cyc = 0; cyc < 60 && writes < 16; cyc++) begin
      tick();
      chk("s3_wfull_low", wfull, 0);
      chk($sformatf("s3_wafull_%0d", writes), wafull, af_exp(writes));
      if (ack0) begin
        chk($sformatf("s3_addr_%0d", writes), mem_waddr, writes);
        writes++;
      end
    end
    chk("s3_write_count", writes, 16);
    tick();
    chk("s3_full", wfull, 1);
    chk("s3_full_wafull", wafull, af_exp(16));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s3_stall_ack0_%0d", k), ack0, 0);
      chk($sformatf("s3_stall_we_%0d", k), mem_we, 0);
      tick();
    end
    chk("s3_stall_wfull", wfull, 1);
    w_rptr = 5'b00001;
    tick();
    chk("s3_release_wfull", wfull, 0);
    chk("s3_release_ack0", ack0, 1);
    chk("s3_release_addr", mem_waddr, 0);
    tick();
    chk("s3_refull", wfull, 1);
    chk("s3_refull_ack0", ack0, 0);

    // Reset during the second word of an OWN1 burst
    do_reset();
    req1 = 1'b1;
    tick();
    chk("s4_w0_ack1", ack1, 1);
    tick();
    chk("s4_w1_ack1", ack1, 1);
    chk("s4_w1_wptr", wptr, 1);
    wrst = 1'b1;
    tick();
    wrst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("s4_rst_ack0", ack0, 0);
    chk("s4_rst_ack1", ack1, 0);
    chk("s4_rst_we", mem_we, 0);
    chk("s4_rst_wptr", wptr, 0);
    chk("s4_rst_wfull", wfull, 0);
    tick();
    chk("s4_grant_ack0", ack0, 1);
    chk("s4_grant_ack1", ack1, 0);
    chk("s4_grant_addr", mem_waddr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
